mmio_uart_ctrl: RTL and testbench
=================================

// Module: mmio_uart_ctrl
// PURPOSE
//   Memory-mapped I/O controller between the core's EX-stage address/data bus and uart_receiver/uart_transmitter.
//   Replaces the fixed single-byte UART decode with parametrised RX/TX byte FIFOs, sticky overflow flags and
//   cycle/instruction counters. Read data returns one cycle after the request, aligned with the WB-stage memory mux.
// PARAMETERS
//   BASE_ADDR  32'h8000_0000  MMIO window base; the window is 32 bytes (offsets 0x00-0x1F)
//   RX_DEPTH   8              RX FIFO entries; power of 2, >=2
//   TX_DEPTH   8              TX FIFO entries; power of 2, >=2
//   CNT_WIDTH  32             counter width, <=32; read value is zero-extended to 32 bits
// PORTS
//   clk            in   1   core clock
//   rst_n          in   1   asynchronous, active-low reset
//   mmio_addr      in   32  byte address from EX stage
//   mmio_re        in   1   read request (load)
//   mmio_we        in   4   byte write enables (store); any bit set = write
//   mmio_wdata     in   32  store data
//   mmio_hit       out  1   combinational; addr[31:5]==BASE_ADDR[31:5]
//   mmio_rdata     out  32  registered read data, valid the cycle after mmio_re
//   inst_retired   in   1   one pulse per retired instruction
//   uart_rx_data   in   8   byte from receiver
//   uart_rx_valid  in   1   receiver byte valid
//   uart_rx_ready  out  1   registered; 0 in reset, 1 afterwards
//   uart_tx_data   out  8   TX FIFO head
//   uart_tx_valid  out  1   TX FIFO not empty
//   uart_tx_ready  in   1   transmitter ready
// BEHAVIOUR
//   Access: a read or write takes effect only when mmio_hit=1. Offsets are word aligned; addr[1:0] is ignored.
//   Register map:
//     0x00 STATUS (R/W)
//       read: bit0 tx_not_full, bit1 rx_not_empty, bit2 rx_ovf, bit3 tx_ovf, others 0
//       write: wdata[2]=1 clears rx_ovf; wdata[3]=1 clears tx_ovf
//     0x04 RXDATA (R)  {24'b0, head}; pops 1 entry. Reading when empty returns 0 with no pointer change.
//     0x08 TXDATA (W)  pushes wdata[7:0]. Writing when full drops the byte and sets tx_ovf.
//     0x10 CYCLE  (R)  free-running cycle counter
//     0x14 INSTR  (R)  count of inst_retired pulses
//     0x18 CLEAR  (W)  any write zeroes both counters
//     other offsets: reads return 0, writes have no effect
//   mmio_rdata: registered, 1-cycle latency. It is 0 in every cycle not following a hit read.
//   RX FIFO:
//     push when uart_rx_valid & uart_rx_ready. If full and no pop in the same cycle, the byte is dropped and rx_ovf is set.
//     full with a simultaneous pop: the push is accepted, count is unchanged, no overflow.
//     empty with a simultaneous pop: the pop returns 0 and the byte is stored.
//   TX FIFO:
//     pop when uart_tx_valid & uart_tx_ready; uart_tx_data = head, combinational from storage.
//     A simultaneous push and pop is always legal: when full the push is accepted, when empty the push only lands.
//   Pointers: log2(DEPTH)+1 bits with wrap bit. full = addr bits equal and wrap bits differ; empty = pointers equal.
//   Counters:
//     CYCLE +1 every clk and INSTR +1 on inst_retired; both wrap at 2^CNT_WIDTH to 0.
//     A CLEAR write wins over a same-cycle increment: the value is 0 on the next cycle.
//     A CYCLE read returns the pre-edge value.
//   Sticky flags: a same-cycle set and clear leaves the flag at 1 (the set wins).
//   Reset, rst_n low at any time, including mid-transfer:
//     FIFOs empty; counters and flags 0; mmio_rdata=0, uart_rx_ready=0, uart_tx_valid=0.
//     In-flight bytes are discarded. Release is synchronised to clk internally.
// TESTING
//   1. After reset, read 0x00 -> rdata=32'h1 on the next cycle; read 0x04 -> 0; uart_tx_valid=0.
//   2. Write 0x41,0x42 to 0x08 with uart_tx_ready=1 -> uart_tx_data 0x41 then 0x42 on consecutive pops; valid then drops.
//   3. Hold uart_tx_ready=0 and write TX_DEPTH+1 bytes -> status bit0=0, bit3=1; write 0x8 to 0x00 -> bit3=0.
//   4. Inject RX_DEPTH+1 bytes with no reads -> bit2=1; read 0x04 RX_DEPTH times -> bytes 1..RX_DEPTH in order, then 0.
//   5. RX FIFO full, push and pop of 0x04 in the same cycle -> no overflow, count stays RX_DEPTH, FIFO order preserved.
//   6. Run 100 cycles with 37 inst_retired pulses and read 0x14 -> 37; write 0x18 while inst_retired=1 -> INSTR=0;
//      drop rst_n mid-TX -> uart_tx_valid=0 immediately.

Source files
------------

// File: rtl/mmio_uart_ctrl.sv
// MMIO bridge between the core load/store path and the UART pair: RX/TX byte FIFOs,
// sticky overflow flags and cycle/instruction counters behind a 32-byte register window.

module mmio_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] wr_ptr_d, rd_ptr_d;

    // Callers only assert push/pop when legal, so the pointers just advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
endmodule

module mmio_uart_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          RX_DEPTH  = 8,
    parameter int          TX_DEPTH  = 8,
    parameter int          CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mmio_addr,
    input  logic        mmio_re,
    input  logic [3:0]  mmio_we,
    input  logic [31:0] mmio_wdata,
    output logic        mmio_hit,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retired,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);
    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_RXDATA = 3'd1;
    localparam logic [2:0] OFF_TXDATA = 3'd2;
    localparam logic [2:0] OFF_CYCLE  = 3'd4;
    localparam logic [2:0] OFF_INSTR  = 3'd5;
    localparam logic [2:0] OFF_CLEAR  = 3'd6;

    // Reset asserts asynchronously but releases two clocks later, in step with clk.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    logic [2:0] off;
    logic       rd_en, wr_en;

    assign mmio_hit = (mmio_addr[31:5] == BASE_ADDR[31:5]);
    assign off      = mmio_addr[4:2];
    assign rd_en    = mmio_hit & mmio_re;
    assign wr_en    = mmio_hit & (|mmio_we);

    logic unused_bits;
    assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:8]};

    logic       rx_ready_q;
    logic       rx_in, rx_push, rx_pop, rx_full, rx_empty, rx_ovf_set;
    logic [7:0] rx_head;

    assign rx_in      = uart_rx_valid & rx_ready_q;
    assign rx_pop     = rd_en & (off == OFF_RXDATA) & ~rx_empty;
    assign rx_push    = rx_in & (~rx_full | rx_pop);
    assign rx_ovf_set = rx_in & rx_full & ~rx_pop;

    mmio_uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (uart_rx_data),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    logic tx_req, tx_push, tx_pop, tx_full, tx_empty, tx_ovf_set;

    assign tx_req     = wr_en & (off == OFF_TXDATA);
    assign tx_pop     = ~tx_empty & uart_tx_ready;
    assign tx_push    = tx_req & (~tx_full | tx_pop);
    assign tx_ovf_set = tx_req & tx_full & ~tx_pop;

    mmio_uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (mmio_wdata[7:0]),
        .head_o  (uart_tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    assign uart_tx_valid = ~tx_empty;
    assign uart_rx_ready = rx_ready_q;

    logic                 rx_ovf_q, tx_ovf_q, rx_ovf_d, tx_ovf_d;
    logic                 stat_wr, cnt_clr;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d, instr_q, instr_d;
    logic [31:0]          rdata_q, rdata_d;

    assign stat_wr = wr_en & (off == OFF_STATUS);
    assign cnt_clr = wr_en & (off == OFF_CLEAR);

    // A set in the same cycle as a software clear keeps the flag high.
    always_comb begin
        rx_ovf_d = (rx_ovf_q & ~(stat_wr & mmio_wdata[2])) | rx_ovf_set;
        tx_ovf_d = (tx_ovf_q & ~(stat_wr & mmio_wdata[3])) | tx_ovf_set;
        cyc_d    = cnt_clr ? '0 : cyc_q + 1'b1;
        instr_d  = cnt_clr ? '0 : instr_q + CNT_WIDTH'(inst_retired);
    end

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (off)
                OFF_STATUS: rdata_d = {28'b0, tx_ovf_q, rx_ovf_q, ~rx_empty, ~tx_full};
                OFF_RXDATA: rdata_d = rx_empty ? 32'b0 : {24'b0, rx_head};
                OFF_CYCLE:  rdata_d = 32'(cyc_q);
                OFF_INSTR:  rdata_d = 32'(instr_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rx_ready_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            cyc_q      <= '0;
            instr_q    <= '0;
            rdata_q    <= '0;
        end else begin
            rx_ready_q <= 1'b1;
            rx_ovf_q   <= rx_ovf_d;
            tx_ovf_q   <= tx_ovf_d;
            cyc_q      <= cyc_d;
            instr_q    <= instr_d;
            rdata_q    <= rdata_d;
        end
    end

    assign mmio_rdata = rdata_q;
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: register map, FIFO boundaries, sticky flags, counters, reset.

module tb_mmio_uart_ctrl;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mmio_addr;
    logic        mmio_re;
    logic [3:0]  mmio_we;
    logic [31:0] mmio_wdata;
    logic        mmio_hit;
    logic [31:0] mmio_rdata;
    logic        inst_retired;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    int n_chk  = 0;
    int n_fail = 0;

    mmio_uart_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mmio_addr     (mmio_addr),
        .mmio_re       (mmio_re),
        .mmio_we       (mmio_we),
        .mmio_wdata    (mmio_wdata),
        .mmio_hit      (mmio_hit),
        .mmio_rdata    (mmio_rdata),
        .inst_retired  (inst_retired),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mmio_rd(input logic [31:0] addr, output logic [31:0] d);
        mmio_addr = addr;
        mmio_re   = 1'b1;
        tick();
        d         = mmio_rdata;
        mmio_re   = 1'b0;
        mmio_addr = 32'h0;
    endtask

    task automatic mmio_wr(input logic [31:0] addr, input logic [31:0] data);
        mmio_addr  = addr;
        mmio_wdata = data;
        mmio_we    = 4'hF;
        tick();
        mmio_we    = 4'h0;
        mmio_addr  = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) tick();
        n_chk++; if (mmio_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", mmio_rdata); end
        n_chk++; if (uart_rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", uart_rx_ready); end
        n_chk++; if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", uart_tx_valid); end
        rst_n = 1'b1;
        repeat (4) tick();
        n_chk++; if (uart_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_after: got %b want 1", uart_rx_ready); end
        mmio_rd(BASE + 32'h0, d);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL status_reset: got %h want 1", d); end
        tick();
        n_chk++; if (mmio_rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_idle: got %h want 0", mmio_rdata); end
        mmio_rd(BASE + 32'h4, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rxdata_empty: got %h want 0", d); end
        mmio_rd(BASE + 32'h3, d);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL status_unaligned: got %h want 1", d); end
        mmio_rd(BASE + 32'h20, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL miss_read: got %h want 0", d); end
        mmio_rd(BASE + 32'hC, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", d); end
        mmio_addr = BASE + 32'h1C; #1;
        n_chk++; if (mmio_hit !== 1'b1) begin n_fail++; $display("FAIL hit_top: got %b want 1", mmio_hit); end
        mmio_addr = BASE + 32'h20; #1;
        n_chk++; if (mmio_hit !== 1'b0) begin n_fail++; $display("FAIL hit_above: got %b want 0", mmio_hit); end
        mmio_addr = 32'h7FFF_FFFC; #1;
        n_chk++; if (mmio_hit !== 1'b0) begin n_fail++; $display("FAIL hit_below: got %b want 0", mmio_hit); end
        mmio_addr = 32'h0;
    endtask

    task automatic test_tx_basic();
        uart_tx_ready = 1'b1;
        mmio_wr(BASE + 32'h8, 32'h41);
        n_chk++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_first: got v=%b d=%h want v=1 d=41", uart_tx_valid, uart_tx_data); end
        mmio_wr(BASE + 32'h8, 32'h42);
        n_chk++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h42) begin n_fail++; $display("FAIL tx_second: got v=%b d=%h want v=1 d=42", uart_tx_valid, uart_tx_data); end
        tick();
        n_chk++; if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drain: got v=%b want 0", uart_tx_valid); end
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        uart_tx_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) mmio_wr(BASE + 32'h8, 32'h10 + i);
        mmio_rd(BASE + 32'h0, d);
        n_chk++; if (d !== 32'h8) begin n_fail++; $display("FAIL tx_ovf_status: got %h want 8", d); end
        mmio_wr(BASE + 32'h0, 32'h8);
        mmio_rd(BASE + 32'h0, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL tx_ovf_clear: got %h want 0", d); end
        uart_tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_chk++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'(32'h10 + i)) begin n_fail++; $display("FAIL tx_order[%0d]: got v=%b d=%h want d=%h", i, uart_tx_valid, uart_tx_data, 8'(32'h10 + i)); end
            tick();
        end
        n_chk++; if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_dropped_extra: got v=%b want 0", uart_tx_valid); end
        uart_tx_ready = 1'b0;
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            uart_rx_data = 8'(i); uart_rx_valid = 1'b1;
            tick();
        end
        uart_rx_valid = 1'b0;
        mmio_rd(BASE + 32'h0, d);
        n_chk++; if (d !== 32'h7) begin n_fail++; $display("FAIL rx_ovf_status: got %h want 7", d); end
        for (int i = 1; i <= DEPTH; i++) begin
            mmio_rd(BASE + 32'h4, d);
            n_chk++; if (d !== 32'(i)) begin n_fail++; $display("FAIL rx_order[%0d]: got %h want %h", i, d, i); end
        end
        mmio_rd(BASE + 32'h4, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_after_drain: got %h want 0", d); end
        mmio_wr(BASE + 32'h0, 32'h4);
        mmio_rd(BASE + 32'h0, d);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL rx_ovf_clear: got %h want 1", d); end
    endtask

    task automatic test_rx_full_pushpop();
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            uart_rx_data = 8'(8'h21 + i); uart_rx_valid = 1'b1;
            tick();
        end
        uart_rx_data = 8'h29;
        mmio_addr = BASE + 32'h4; mmio_re = 1'b1;
        tick();
        d = mmio_rdata;
        mmio_re = 1'b0; uart_rx_valid = 1'b0; mmio_addr = 32'h0;
        n_chk++; if (d !== 32'h21) begin n_fail++; $display("FAIL rx_full_pop: got %h want 21", d); end
        mmio_rd(BASE + 32'h0, d);
        n_chk++; if (d !== 32'h3) begin n_fail++; $display("FAIL rx_full_no_ovf: got %h want 3", d); end
        for (int i = 0; i < DEPTH; i++) begin
            mmio_rd(BASE + 32'h4, d);
            n_chk++; if (d !== 32'h22 + i) begin n_fail++; $display("FAIL rx_full_order[%0d]: got %h want %h", i, d, 32'h22 + i); end
        end
        mmio_rd(BASE + 32'h4, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_full_count: got %h want 0", d); end
        // Empty FIFO: same-cycle pop returns 0 while the byte is stored.
        uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
        mmio_addr = BASE + 32'h4; mmio_re = 1'b1;
        tick();
        d = mmio_rdata;
        mmio_re = 1'b0; uart_rx_valid = 1'b0; mmio_addr = 32'h0;
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rx_empty_pop: got %h want 0", d); end
        mmio_rd(BASE + 32'h4, d);
        n_chk++; if (d !== 32'h5A) begin n_fail++; $display("FAIL rx_empty_stored: got %h want 5a", d); end
    endtask

    task automatic test_sticky_set_wins();
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            uart_rx_data = 8'(8'h31 + i); uart_rx_valid = 1'b1;
            tick();
        end
        uart_rx_data = 8'h99;
        mmio_addr = BASE + 32'h0; mmio_wdata = 32'h4; mmio_we = 4'hF;
        tick();
        mmio_we = 4'h0; uart_rx_valid = 1'b0; mmio_addr = 32'h0;
        mmio_rd(BASE + 32'h0, d);
        n_chk++; if (d !== 32'h7) begin n_fail++; $display("FAIL sticky_set_wins: got %h want 7", d); end
        mmio_rd(BASE + 32'h4, d);
        n_chk++; if (d !== 32'h31) begin n_fail++; $display("FAIL sticky_head: got %h want 31", d); end
    endtask

    task automatic test_counters();
        logic [31:0] d;
        mmio_wr(BASE + 32'h18, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retired = (i < 37);
            tick();
        end
        inst_retired = 1'b0;
        mmio_rd(BASE + 32'h14, d);
        n_chk++; if (d !== 32'd37) begin n_fail++; $display("FAIL instr_count: got %0d want 37", d); end
        inst_retired = 1'b1;
        mmio_wr(BASE + 32'h18, 32'h0);
        inst_retired = 1'b0;
        mmio_rd(BASE + 32'h14, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL instr_clear_wins: got %0d want 0", d); end
        mmio_wr(BASE + 32'h18, 32'h0);
        mmio_rd(BASE + 32'h10, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL cycle_clear_wins: got %0d want 0", d); end
        mmio_wr(BASE + 32'h18, 32'h0);
        repeat (5) tick();
        mmio_rd(BASE + 32'h10, d);
        n_chk++; if (d !== 32'd5) begin n_fail++; $display("FAIL cycle_count: got %0d want 5", d); end
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d;
        uart_tx_ready = 1'b0;
        mmio_wr(BASE + 32'h8, 32'hA1);
        mmio_wr(BASE + 32'h8, 32'hA2);
        inst_retired = 1'b1;
        repeat (3) tick();
        inst_retired = 1'b0;
        n_chk++; if (uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", uart_tx_valid); end
        uart_tx_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_tx_valid: got %b want 0", uart_tx_valid); end
        n_chk++; if (uart_rx_ready !== 1'b0) begin n_fail++; $display("FAIL async_rx_ready: got %b want 0", uart_rx_ready); end
        uart_tx_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        mmio_rd(BASE + 32'h0, d);
        n_chk++; if (d !== 32'h1) begin n_fail++; $display("FAIL post_reset_status: got %h want 1", d); end
        mmio_rd(BASE + 32'h14, d);
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL post_reset_instr: got %0d want 0", d); end
        n_chk++; if (uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_tx_valid: got %b want 0", uart_tx_valid); end
    endtask

    initial begin
        rst_n = 1'b0; mmio_addr = 32'h0; mmio_re = 1'b0; mmio_we = 4'h0; mmio_wdata = 32'h0;
        inst_retired = 1'b0; uart_rx_data = 8'h0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_overflow();
        test_rx_full_pushpop();
        do_reset();
        test_sticky_set_wins();
        do_reset();
        test_counters();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
